ps2_device_tx: RTL and testbench
================================

// Module: ps2_device_tx
// PURPOSE
//  Device end of the PS/2 link: emulates a keyboard/mouse towards a PS/2 host.
//  Generates the PS/2 clock itself and serialises bytes device->host (start,
//  8 data LSB first, odd parity, stop). Honours host inhibit and retries
//  automatically. Sits between a scancode/packet source and the open-drain pins.
// PARAMETERS
//  HALF_PERIOD   160   clk cycles per PS/2 clock half-period (40us @4MHz = 12.5kHz)
//  IDLE_HOLD     200   cycles clk AND data must both read high before a frame starts
//  SETTLE        8     cycles after releasing ps2clk before sampling it for inhibit
// PORTS
//  clk           in    1  system clock (1..600 MHz; parameters sized for it)
//  rst           in    1  asynchronous, active-high reset
//  data          in    8  byte to send
//  dataload      in    1  1-cycle strobe: latch data, start frame
//  busy          out   1  high from dataload until done
//  done          out   1  1-cycle pulse: stop bit clocked, frame complete
//  aborted       out   1  1-cycle pulse: host inhibited frame; retry pending
//  ps2clk_ext    inout 1  open drain: driven 0 or Z only
//  ps2data_ext   inout 1  open drain: driven 0 or Z only
//  rx_data       out   8  host command byte        (PS2DEV_HOSTCMD_EN only)
//  rx_valid      out   1  1-cycle pulse, good byte  (PS2DEV_HOSTCMD_EN only)
//  rx_error      out   1  1-cycle pulse, bad parity/stop (PS2DEV_HOSTCMD_EN only)
// BEHAVIOUR
//  - Reset: state IDLE; busy/done/aborted/rx_* = 0; both pins Z combinationally
//    from state, so lines release in the same cycle rst rises (mid-frame too).
//  - Pins sampled through 2-FF synchronisers; all decisions use synced values.
//  - dataload when busy=0: latch byte, busy<=1, go CHKBUS. When busy=1: ignored.
//  - CHKBUS: counter of consecutive cycles with clk=1,data=1; reaches IDLE_HOLD
//    -> TX with bit index 0. Any low sample clears counter.
//  - TX, per bit n=0..10 (frame bits 0,d0..d7,par,1; par = ~^data):
//    phase H: data pin set (0 or Z), clk Z, HALF_PERIOD cycles;
//    phase L: clk driven 0, HALF_PERIOD cycles; then next bit.
//    Data changes only at start of phase H (clk high).
//  - Inhibit: in phase H, from cycle SETTLE onward, synced clk=0 while n<=9
//    -> release both pins, aborted pulse, byte kept, busy stays 1, go CHKBUS
//    (whole frame resent). Clk low during bit 10 is ignored: frame counts as sent.
//  - After phase L of bit 10: release pins, wait one HALF_PERIOD, done pulse,
//    busy<=0, IDLE. dataload in that same cycle is accepted (back-to-back).
//  - Counters: HALF_PERIOD/IDLE_HOLD counters saturate-free, width
//    $clog2(max)+1; bit index 4 bits, never exceeds 10.
// CONFIGURATION
//  PS2DEV_HOSTCMD_EN defined: in IDLE/CHKBUS, clk=1 with data=0 held IDLE_HOLD
//    cycles = host request-to-send; has priority over pending TX (byte kept,
//    resent afterwards). Device generates 11 clocks; samples data at each
//    release of clk (after SETTLE): d0..d7, parity, stop. Good parity and
//    stop=1 -> drive data 0 for a 12th clock (ACK), rx_data valid, rx_valid
//    pulse. Otherwise no ACK, rx_error pulse. Then IDLE/CHKBUS.
//  Undefined: rx_* tied 0; data=0 with clk=1 simply blocks CHKBUS.
// TESTING
//  1 dataload 0x1C, idle host -> 11 falling clk edges, data bits
//    0,0,0,1,1,1,0,0,0,0,1; period 2*HALF_PERIOD; one done pulse; busy falls.
//  2 dataload 0xFF -> parity bit 1; 0x00 -> parity bit 1; 0x01 -> parity 0.
//  3 host holds clk low 100us after 4th falling edge -> aborted pulse, pins Z;
//    after release + IDLE_HOLD, full 0x1C frame resent, single done.
//  4 dataload during busy with 0x55 -> ignored; frame on wire stays original byte.
//  5 rst asserted mid bit 5 with clk driven low -> both pins Z same cycle;
//    busy=0; no done/aborted after rst falls.
//  6 (HOSTCMD_EN) host sends 0xED, parity 1 -> ACK low on 12th clock, rx_valid
//    with rx_data=0xED; repeat with parity 0 -> rx_error, no ACK.

Source files
------------

// File: rtl/ps2_device_tx.sv
// rtl/ps2_device_tx.sv - PS/2 device-side transmitter with host inhibit and automatic retry
// Optional feature macro: PS2DEV_HOSTCMD_EN (host request-to-send receive path with ACK)
module ps2_device_tx #(
  parameter int HALF_PERIOD = 160,
  parameter int IDLE_HOLD   = 200,
  parameter int SETTLE      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       dataload,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  inout  wire        ps2clk_ext,
  inout  wire        ps2data_ext,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error
);

  localparam int CNT_MAX = (HALF_PERIOD > IDLE_HOLD) ? HALF_PERIOD : IDLE_HOLD;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] IH_LAST = CW'(IDLE_HOLD - 1);
  localparam logic [CW-1:0] ST      = CW'(SETTLE);

  typedef enum logic [2:0] {IDLE, CHKBUS, TX, TXEND, RX, RXACK} state_t;

  state_t        state;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_s;
  logic          data_s;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic          phase_low;
  logic [7:0]    byte_q;
  logic [10:0]   tx_sh;
  logic          load_ok;
  logic          drive_clk;
  logic          drive_data;

`ifdef PS2DEV_HOSTCMD_EN
  logic [CW-1:0] rts_cnt;
  logic [9:0]    rx_sh;
`else
  assign rx_data  = '0;
  assign rx_valid = 1'b0;
  assign rx_error = 1'b0;
`endif

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // A new byte is taken when idle, or in the very cycle the previous frame completes.
  assign load_ok = dataload && (!busy || (state == TXEND && cnt == HP_LAST));

  // Pin drivers decode straight from state so an async reset releases the bus at once.
  assign drive_clk  = (state inside {TX, RX, RXACK}) && phase_low;
  assign drive_data = (state == TX && !tx_sh[0]) || (state == RXACK);

  assign ps2clk_ext  = drive_clk  ? 1'b0 : 1'bz;
  assign ps2data_ext = drive_data ? 1'b0 : 1'bz;

  // Two-flop synchronisers for the open-drain lines; idle level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2clk_ext};
      data_sync <= {data_sync[0], ps2data_ext};
    end
  end

  // Link FSM: bus-idle check, bit-serial transmit with inhibit abort, optional host receive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      phase_low <= 1'b0;
      byte_q    <= '0;
      tx_sh     <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
`ifdef PS2DEV_HOSTCMD_EN
      rts_cnt   <= '0;
      rx_sh     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
`ifdef PS2DEV_HOSTCMD_EN
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
`endif
      if (load_ok) begin
        byte_q <= data;
        busy   <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (load_ok) begin
            state <= CHKBUS;
            cnt   <= '0;
          end
        end
        CHKBUS: begin
          if (clk_s && data_s) begin
            if (cnt == IH_LAST) begin
              state     <= TX;
              cnt       <= '0;
              bit_idx   <= '0;
              phase_low <= 1'b0;
              tx_sh     <= {1'b1, ~^byte_q, byte_q, 1'b0};
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
        TX: begin
          cnt <= cnt + 1'b1;
          if (!phase_low) begin
            // Host holding clock low during our high phase is an inhibit, except on the stop bit.
            if (cnt >= ST && !clk_s && bit_idx <= 4'd9) begin
              aborted <= 1'b1;
              state   <= CHKBUS;
              cnt     <= '0;
            end else if (cnt == HP_LAST) begin
              phase_low <= 1'b1;
              cnt       <= '0;
            end
          end else if (cnt == HP_LAST) begin
            cnt       <= '0;
            phase_low <= 1'b0;
            if (bit_idx == 4'd10) begin
              state <= TXEND;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx_sh   <= {1'b1, tx_sh[10:1]};
            end
          end
        end
        TXEND: begin
          if (cnt == HP_LAST) begin
            done <= 1'b1;
            cnt  <= '0;
            if (load_ok) begin
              state <= CHKBUS;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef PS2DEV_HOSTCMD_EN
        RX: begin
          cnt <= cnt + 1'b1;
          if (phase_low) begin
            if (cnt == HP_LAST) begin
              phase_low <= 1'b0;
              cnt       <= '0;
            end
          end else begin
            // Sample after the clock has settled high; the first sample is the start bit.
            if (cnt == ST && bit_idx != 4'd0) rx_sh <= {data_s, rx_sh[9:1]};
            if (cnt == HP_LAST) begin
              cnt <= '0;
              if (bit_idx == 4'd10) begin
                if (rx_sh[9] && ^rx_sh[8:0]) begin
                  state     <= RXACK;
                  phase_low <= 1'b1;
                end else begin
                  rx_error <= 1'b1;
                  state    <= (busy || load_ok) ? CHKBUS : IDLE;
                end
              end else begin
                bit_idx   <= bit_idx + 4'd1;
                phase_low <= 1'b1;
              end
            end
          end
        end
        RXACK: begin
          cnt <= cnt + 1'b1;
          if (cnt == HP_LAST) begin
            cnt <= '0;
            if (phase_low) begin
              phase_low <= 1'b0;
            end else begin
              rx_data  <= rx_sh[7:0];
              rx_valid <= 1'b1;
              state    <= (busy || load_ok) ? CHKBUS : IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
`ifdef PS2DEV_HOSTCMD_EN
      // Host request-to-send pre-empts a pending transmit; the byte stays queued.
      if ((state == IDLE || state == CHKBUS) && clk_s && !data_s) begin
        if (rts_cnt == IH_LAST) begin
          state     <= RX;
          phase_low <= 1'b1;
          cnt       <= '0;
          bit_idx   <= '0;
          rts_cnt   <= '0;
        end else begin
          rts_cnt <= rts_cnt + 1'b1;
        end
      end else begin
        rts_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb/tb_ps2_device_tx.sv - scoreboard bench for ps2_device_tx (PS2DEV_HOSTCMD_EN adds host-command case)
module tb_ps2_device_tx;

  localparam int HP = 20;
  localparam int IH = 30;
  localparam int ST = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       dataload;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       host_clk_low;
  logic       host_data_low;
  logic       host_tx;
  wire        ps2clk;
  wire        ps2data;

  assign ps2clk  = host_clk_low  ? 1'b0 : 1'bz;
  assign ps2data = host_data_low ? 1'b0 : 1'bz;
  pullup (ps2clk);
  pullup (ps2data);

  ps2_device_tx #(.HALF_PERIOD(HP), .IDLE_HOLD(IH), .SETTLE(ST)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dataload   (dataload),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .ps2clk_ext (ps2clk),
    .ps2data_ext(ps2data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_error   (rx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [10:0] exp_q[$];
  int          nbits = 0;
  int          done_cnt = 0;
  int          abort_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic p);
    return {1'b1, p, b, 1'b0};
  endfunction

  // Wire monitor: captures data at each falling PS/2 clock and scores complete frames.
  initial begin
    logic [10:0] cap;
    logic [10:0] exp;
    logic        clk_prev;
    int          cyc;
    int          t_first;
    cap = '0;
    clk_prev = 1'b1;
    cyc = 0;
    t_first = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        nbits = 0;
      end else begin
        if (done) done_cnt++;
        if (aborted) begin
          abort_cnt++;
          nbits = 0;
        end
        if (!host_tx && clk_prev === 1'b1 && ps2clk === 1'b0) begin
          if (nbits == 0) t_first = cyc;
          cap = {ps2data, cap[10:1]};
          nbits++;
          if (nbits == 11) begin
            nbits = 0;
            check("clk_period", 32'(cyc - t_first), 32'(20 * HP));
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 32'(cap), 32'h7ff_ffff);
            end else begin
              exp = exp_q.pop_front();
              check("frame", 32'(cap), 32'(exp));
            end
          end
        end
      end
      clk_prev = ps2clk;
    end
  end

  task automatic send(input logic [7:0] b, input logic [10:0] exp, input bit accept);
    @(negedge clk);
    data = b;
    dataload = 1'b1;
    if (accept) exp_q.push_back(exp);
    @(negedge clk);
    dataload = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_cnt - start), 32'd1);
  endtask

  task automatic wait_bits(input int k);
    int n;
    n = 0;
    while (nbits < k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit", 32'(nbits >= k), 32'd1);
  endtask

`ifdef PS2DEV_HOSTCMD_EN
  task automatic host_send(input logic [7:0] b, input logic p, input bit expect_ok);
    logic [9:0] bits;
    logic       prev;
    logic       ack_seen;
    logic       v;
    logic       e;
    logic [7:0] got;
    logic [7:0] rx_q[$];
    int         falls;
    int         n;
    bits = {1'b1, p, b};
    prev = 1'b1;
    ack_seen = 1'b0;
    v = 1'b0;
    e = 1'b0;
    got = '0;
    falls = 0;
    n = 0;
    if (expect_ok) rx_q.push_back(b);
    host_tx = 1'b1;
    host_data_low = 1'b1;
    while (n < 4000 && !(v || e)) begin
      @(negedge clk);
      n++;
      if (rx_valid) begin
        v = 1'b1;
        got = rx_data;
      end
      if (rx_error) e = 1'b1;
      if (prev === 1'b1 && ps2clk === 1'b0) begin
        falls++;
        if (falls >= 2 && falls <= 11) begin
          host_data_low = ~bits[0];
          bits = {1'b1, bits[9:1]};
        end
      end
      if (falls == 12 && ps2clk === 1'b0 && ps2data === 1'b0) ack_seen = 1'b1;
      prev = ps2clk;
    end
    host_data_low = 1'b0;
    host_tx = 1'b0;
    check("rx_ack", 32'(ack_seen), 32'(expect_ok));
    check("rx_valid", 32'(v), 32'(expect_ok));
    check("rx_error", 32'(e), 32'(!expect_ok));
    if (v) begin
      if (rx_q.size() == 0) check("rx_unexpected", 32'(got), 32'h1ff);
      else check("rx_data", 32'(got), 32'(rx_q.pop_front()));
    end
  endtask
`endif

  logic [7:0] par_bytes[3] = '{8'hFF, 8'h00, 8'h01};
  logic       par_bits[3]  = '{1'b1, 1'b1, 1'b0};

  initial begin
    int d0;
    int a0;
    rst = 1'b1;
    data = '0;
    dataload = 1'b0;
    host_clk_low = 1'b0;
    host_data_low = 1'b0;
    host_tx = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_clk_pin", 32'(ps2clk), 32'd1);
    check("rst_data_pin", 32'(ps2data), 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Plain frame, idle host: bits 0,0,0,1,1,1,0,0,0,0,1 on the wire.
    d0 = done_cnt;
    send(8'h1C, 11'b1_0_00011100_0, 1'b1);
    check("busy_in_frame", 32'(busy), 32'd1);
    wait_done(d0);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    repeat (2 * HP) @(negedge clk);
    check("done_once", 32'(done_cnt - d0), 32'd1);

    // Parity corner bytes.
    for (int i = 0; i < 3; i++) begin
      d0 = done_cnt;
      send(par_bytes[i], mk_frame(par_bytes[i], par_bits[i]), 1'b1);
      wait_done(d0);
      repeat (5) @(negedge clk);
    end

    // Host inhibit after the 4th falling edge, then full resend.
    d0 = done_cnt;
    a0 = abort_cnt;
    send(8'h1C, 11'b1_0_00011100_0, 1'b1);
    wait_bits(4);
    host_clk_low = 1'b1;
    repeat (3 * HP) @(negedge clk);
    check("abort_pulse", 32'(abort_cnt - a0), 32'd1);
    check("abort_data_released", 32'(ps2data), 32'd1);
    check("abort_busy_held", 32'(busy), 32'd1);
    host_clk_low = 1'b0;
    wait_done(d0);
    repeat (2 * HP) @(negedge clk);
    check("retry_single_done", 32'(done_cnt - d0), 32'd1);
    check("retry_single_abort", 32'(abort_cnt - a0), 32'd1);

    // dataload while busy must not disturb the frame in flight.
    d0 = done_cnt;
    send(8'h1C, 11'b1_0_00011100_0, 1'b1);
    wait_bits(3);
    send(8'h55, 11'b0, 1'b0);
    wait_done(d0);
    repeat (2 * HP) @(negedge clk);
    check("busy_load_done", 32'(done_cnt - d0), 32'd1);

    // Reset mid bit 5 while the device holds clock (and data) low.
    send(8'h00, mk_frame(8'h00, 1'b1), 1'b1);
    wait_bits(6);
    repeat (HP / 2) @(negedge clk);
    check("pre_rst_clk_low", 32'(ps2clk), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_clk_pin", 32'(ps2clk), 32'd1);
    check("rst_mid_data_pin", 32'(ps2data), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    a0 = abort_cnt;
    repeat (30 * HP) @(negedge clk);
    check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("post_rst_no_abort", 32'(abort_cnt - a0), 32'd0);
    check("post_rst_no_bits", 32'(nbits), 32'd0);

`ifdef PS2DEV_HOSTCMD_EN
    host_send(8'hED, 1'b1, 1'b1);
    repeat (2 * HP) @(negedge clk);
    host_send(8'hED, 1'b0, 1'b0);
    repeat (2 * HP) @(negedge clk);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
